// File: rtl/mod7_serial_ctrl.sv
// -----------------------------------------------------------------------------
// mod7_serial_ctrl
//   Computes (in_data mod 7) for a WIDTH-bit unsigned operand. It walks the
//   operand one octal digit per cycle, LSB first, through a 4-bit mod-7 cell.
//   Because 8 mod 7 = 1, every octal digit has weight 1 mod 7, so the running
//   remainder is simply acc <= cell(acc + digit).
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand available on in_data
//   in_ready   out  1      block can accept an operand (IDLE)
//   in_data    in   WIDTH  unsigned operand, sampled only on acceptance
//   clear      in   1      synchronous abort back to IDLE
//   out_valid  out  1      out_rem holds a valid result (DONE)
//   out_ready  in   1      consumer accepts the result
//   out_rem    out  3      remainder 0..6, held until the next result
//   busy       out  1      high while digits are being consumed (RUN)
// -----------------------------------------------------------------------------
module mod7_serial_ctrl #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_rem,
    output logic             busy
);

    localparam int NDIG   = (WIDTH + 2) / 3;
    localparam int OPND_W = 3 * NDIG;
    localparam int CNT_W  = $clog2(NDIG + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // 4-bit mod-7 remainder cell. Inputs here never exceed 13, but the full
    // 4-bit range is mapped so the cell stays correct on its own.
    function automatic logic [2:0] mod7_cell(input logic [3:0] x);
        if (x >= 4'd14) begin
            mod7_cell = 3'(x - 4'd14);
        end else if (x >= 4'd7) begin
            mod7_cell = 3'(x - 4'd7);
        end else begin
            mod7_cell = x[2:0];
        end
    endfunction

    state_t              state_q;
    logic [OPND_W-1:0]   opnd_q;
    logic [2:0]          acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          out_rem_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [OPND_W-1:0]   opnd_init;
    logic [2:0]          acc_d;

    // Zero-extension pads the MSB digit when WIDTH is not a multiple of 3.
    assign opnd_init = OPND_W'(in_data);
    assign acc_d     = mod7_cell({1'b0, acc_q} + {1'b0, opnd_q[2:0]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            opnd_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_rem_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clear) begin
            // Abort from any state; out_rem deliberately keeps its last value.
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        opnd_q     <= opnd_init;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc_q  <= acc_d;
                    opnd_q <= opnd_q >> 3;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Last digit: publish the freshly computed remainder.
                    if (cnt_q == LAST_CNT) begin
                        out_rem_q   <= acc_d;
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_rem   = out_rem_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mod7_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mod7_serial_ctrl
//   Directed and table-driven checks on a WIDTH=12 instance, plus a random
//   sweep against (x % 7) on instances with WIDTH 1, 3, 12, 13 and 32.
// -----------------------------------------------------------------------------
module tb_mod7_serial_ctrl;

    int checks = 0;
    int errors = 0;
    int sw_done = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Main WIDTH=12 instance
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_rem;
    logic        busy;

    mod7_serial_ctrl #(.WIDTH(12)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rem   (out_rem),
        .busy      (busy)
    );

    // Drives one operand from IDLE and waits for out_valid.
    // lat = edges after acceptance until out_valid; bcnt = cycles busy was high.
    task automatic op_main(input logic [11:0] d, output logic [2:0] rem,
                           output int lat, output int bcnt);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
        rem = out_rem;
    endtask

    task automatic release_main(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_idle_in_ready"}, in_ready, 1);
        chk({nm, "_idle_out_valid"}, out_valid, 0);
    endtask

    typedef struct {
        logic [11:0] d;
        logic [2:0]  r;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [2:0] rem;
        int lat, bc, k_done1, k_acc2, k2, seen;

        vecs[0]  = '{12'd1000, 3'd6};
        vecs[1]  = '{12'd4095, 3'd0};
        vecs[2]  = '{12'd2048, 3'd4};
        vecs[3]  = '{12'd100,  3'd2};
        vecs[4]  = '{12'd0,    3'd0};
        vecs[5]  = '{12'd7,    3'd0};
        vecs[6]  = '{12'd6,    3'd6};
        vecs[7]  = '{12'd13,   3'd6};
        vecs[8]  = '{12'd63,   3'd0};
        vecs[9]  = '{12'd4094, 3'd6};
        vecs[10] = '{12'd2047, 3'd3};
        vecs[11] = '{12'd512,  3'd1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rem", out_rem, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // T1: 1000 -> 6, four RUN cycles
        op_main(12'd1000, rem, lat, bc);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_rem", rem, 6);
        chk("t1_latency", lat, 4);
        chk("t1_busy_cycles", bc, 4);
        chk("t1_in_ready_done", in_ready, 0);
        release_main("t1");

        // T2: back-to-back 0xFFF then 0x800 with out_ready held high
        @(negedge clk);
        in_valid = 1'b1; in_data = 12'hFFF; out_ready = 1'b1;
        @(negedge clk);
        in_data = 12'h800;
        k_done1 = -1; k_acc2 = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k_done1 < 0 && out_valid) begin
                k_done1 = k;
                chk("t2_rem1", out_rem, 0);
            end else if (k_done1 >= 0 && busy) begin
                k_acc2 = k;
                break;
            end
        end
        in_valid = 1'b0;
        chk("t2_done1_edge", k_done1, 4);
        chk("t2_accept2_edge", k_acc2, 6);
        k2 = k_acc2;
        while (!out_valid && k2 < 40) begin
            @(negedge clk);
            k2++;
        end
        chk("t2_done2_edge", k2, 10);
        chk("t2_rem2", out_rem, 4);
        @(negedge clk);
        out_ready = 1'b0;
        chk("t2_idle_in_ready", in_ready, 1);

        // T4: 100 -> 2 held in DONE while out_ready is low
        op_main(12'd100, rem, lat, bc);
        chk("t4_rem", rem, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_out_valid", out_valid, 1);
            chk("t4_hold_rem", out_rem, 2);
            chk("t4_hold_in_ready", in_ready, 0);
            in_valid = 1'b1;
            in_data  = 12'd5;
        end
        in_valid = 1'b0;
        release_main("t4");

        // T5: async reset two digits into RUN
        @(negedge clk);
        in_valid = 1'b1; in_data = 12'd1000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy_before_rst", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_in_ready", in_ready, 1);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_out_rem", out_rem, 0);
        @(negedge clk);
        rst = 1'b0;
        op_main(12'd14, rem, lat, bc);
        chk("t5_rem14", rem, 0);
        chk("t5_latency", lat, 4);
        release_main("t5");

        // T6a: clear in DONE
        op_main(12'd55, rem, lat, bc);
        chk("t6_rem55", rem, 6);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t6a_out_valid", out_valid, 0);
        chk("t6a_in_ready", in_ready, 1);
        chk("t6a_out_rem_kept", out_rem, 6);

        // T6b: clear in RUN, then clear beating in_valid in IDLE
        @(negedge clk);
        in_valid = 1'b1; in_data = 12'd9;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6b_busy_in_run", busy, 1);
        clear = 1'b1; in_valid = 1'b1; in_data = 12'd5;
        @(negedge clk);
        chk("t6b_in_ready", in_ready, 1);
        chk("t6b_busy", busy, 0);
        chk("t6b_out_valid", out_valid, 0);
        @(negedge clk);
        chk("t6b_clear_wins_in_ready", in_ready, 1);
        chk("t6b_clear_wins_busy", busy, 0);
        clear = 1'b0; in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        chk("t6b_no_result", seen, 0);
        chk("t6b_out_rem_kept", out_rem, 6);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            op_main(vecs[i].d, rem, lat, bc);
            chk($sformatf("vec%0d_rem", i), rem, 64'(vecs[i].r));
            chk($sformatf("vec%0d_latency", i), lat, 4);
            release_main($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20000 && sw_done < 5; i++) @(negedge clk);
        chk("sweep_done", sw_done, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Random sweep instances
    function automatic int sw_w(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            2:       return 12;
            3:       return 13;
            default: return 32;
        endcase
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_sw
        localparam int W    = sw_w(g);
        localparam int ND   = (W + 2) / 3;
        localparam int NOPS = 25;

        logic         rst_s;
        logic         iv;
        logic         ir;
        logic [W-1:0] din;
        logic         clr;
        logic         ov;
        logic         ordy;
        logic [2:0]   rem;
        logic         bsy;

        mod7_serial_ctrl #(.WIDTH(W)) u_sw (
            .clk       (clk),
            .rst       (rst_s),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_data   (din),
            .clear     (clr),
            .out_valid (ov),
            .out_ready (ordy),
            .out_rem   (rem),
            .busy      (bsy)
        );

        initial begin
            logic [W-1:0]    x;
            longint unsigned xv;
            int              lat, bc, st;

            rst_s = 1'b1; iv = 1'b0; din = '0; clr = 1'b0; ordy = 1'b0;
            repeat (3) @(negedge clk);
            rst_s = 1'b0;
            for (int n = 0; n < NOPS; n++) begin
                if (n == 0)      x = '1;
                else if (n == 1) x = '0;
                else             x = W'($urandom);
                xv = 64'(x);
                @(negedge clk);
                chk($sformatf("w%0d_in_ready", W), ir, 1);
                iv  = 1'b1;
                din = x;
                @(negedge clk);
                iv  = 1'b0;
                din = ~x;
                lat = 0;
                bc  = bsy ? 1 : 0;
                while (!ov && lat < 80) begin
                    @(negedge clk);
                    lat++;
                    if (bsy) bc++;
                end
                chk($sformatf("w%0d_rem_x%0d", W, xv), rem, xv % 7);
                chk($sformatf("w%0d_latency", W), lat, ND);
                chk($sformatf("w%0d_busy_cycles", W), bc, ND);
                st = $urandom_range(0, 2);
                repeat (st) @(negedge clk);
                ordy = 1'b1;
                @(negedge clk);
                ordy = 1'b0;
            end
            sw_done++;
        end
    end

endmodule
